// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path: FSM state encoding,
// default frame geometry and the legal oversampling ratios.
package uart_rx_pkg;

    localparam int DATA_W_DFLT  = 8;
    localparam int PRESC_W_DFLT = 6;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // acc is the XOR of the data bits; a set result means the parity bit disagrees.
    function automatic logic par_check(input logic acc, input logic par_typ, input logic par_bit);
        return acc ^ par_typ ^ par_bit;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and bit counter for the UART receive controller.
// Both counters are held at zero while disabled.
module uart_rx_edge_bit_cnt #(
    parameter int PRESC_W = 6,
    parameter int BIT_W   = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               en_i,
    input  logic               bit_en_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic [PRESC_W-1:0] edge_cnt_o,
    output logic [BIT_W-1:0]   bit_cnt_o,
    output logic               wrap_o
);

    logic [PRESC_W-1:0] edge_q, edge_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               wrap_s;

    assign wrap_s = en_i && (edge_q == (presc_i - PRESC_W'(1)));

    // Next-state for the edge and bit counters
    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        if (!en_i) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (wrap_s) begin
            edge_d = '0;
            if (bit_en_i) begin
                bit_d = bit_q + BIT_W'(1);
            end else begin
                bit_d = bit_q;
            end
        end else begin
            edge_d = edge_q + PRESC_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

    assign edge_cnt_o = edge_q;
    assign bit_cnt_o  = bit_q;
    assign wrap_o     = wrap_s;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detect, bit sequencing, frame checks.
// Define UART_RX_PARITY_EN to add the PAR_EN/PAR_TYP ports and the PARITY state.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DFLT,
    parameter int PRESC_W = PRESC_W_DFLT
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               sampled_bit,
`ifdef UART_RX_PARITY_EN
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
`endif
    output logic               dat_samp_en,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic               deser_New_bit,
    output logic               deser_en,
    output logic               data_valid,
    output logic               strt_err,
    output logic               par_err,
    output logic               stp_err
);

    localparam int BIT_W = $clog2(DATA_W) + 1;

    rx_state_e        state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_s;
    logic             wrap_s, last_bit_s, cnt_en_s, bit_en_s, par_flag_s;
    logic             dv_q, dv_d, se_q, se_d, pe_q, pe_d, sp_q, sp_d;

    assign cnt_en_s   = (state_q != IDLE);
    assign bit_en_s   = (state_q == DATA);
    assign last_bit_s = (bit_cnt_s == BIT_W'(DATA_W - 1));

    uart_rx_edge_bit_cnt #(
        .PRESC_W (PRESC_W),
        .BIT_W   (BIT_W)
    ) u_cnt (
        .CLK        (CLK),
        .RST        (RST),
        .en_i       (cnt_en_s),
        .bit_en_i   (bit_en_s),
        .presc_i    (Prescale),
        .edge_cnt_o (edge_cnt),
        .bit_cnt_o  (bit_cnt_s),
        .wrap_o     (wrap_s)
    );

    // FSM state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; every decision is taken at the last edge of a bit
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!RX_IN) state_d = START;
                else        state_d = IDLE;
            end
            START: begin
                if (wrap_s) begin
                    if (sampled_bit) state_d = IDLE;
                    else             state_d = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (wrap_s && last_bit_s) begin
`ifdef UART_RX_PARITY_EN
                    if (PAR_EN) state_d = PARITY;
                    else        state_d = STOP;
`else
                    state_d = STOP;
`endif
                end else begin
                    state_d = DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (wrap_s) state_d = STOP;
                else        state_d = PARITY;
            end
`endif
            STOP: begin
                if (wrap_s) state_d = IDLE;
                else        state_d = STOP;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; the shift strobe is combinational so the deserializer
    // captures sampled_bit on the same edge the controller decides on
    always_comb begin
        dat_samp_en   = 1'b1;
        deser_en      = 1'b0;
        deser_New_bit = 1'b0;
        case (state_q)
            IDLE: dat_samp_en = 1'b0;
            DATA: begin
                deser_en      = 1'b1;
                deser_New_bit = wrap_s;
            end
            default: begin
                deser_en      = 1'b0;
                deser_New_bit = 1'b0;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic acc_q, acc_d, par_flag_q, par_flag_d;

    // Running data parity and the latched parity verdict for this frame
    always_comb begin
        acc_d      = acc_q;
        par_flag_d = par_flag_q;
        case (state_q)
            IDLE: begin
                acc_d      = 1'b0;
                par_flag_d = 1'b0;
            end
            DATA: begin
                if (wrap_s) acc_d = acc_q ^ sampled_bit;
                else        acc_d = acc_q;
            end
            PARITY: begin
                if (wrap_s) par_flag_d = par_check(acc_q, PAR_TYP, sampled_bit);
                else        par_flag_d = par_flag_q;
            end
            default: begin
                acc_d      = acc_q;
                par_flag_d = par_flag_q;
            end
        endcase
    end

    // Parity registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc_q      <= 1'b0;
            par_flag_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            par_flag_q <= par_flag_d;
        end
    end

    assign par_flag_s = par_flag_q;
`else
    assign par_flag_s = 1'b0;
`endif

    // Frame verdict pulses; stop error outranks parity error
    always_comb begin
        dv_d = 1'b0;
        se_d = 1'b0;
        pe_d = 1'b0;
        sp_d = 1'b0;
        case (state_q)
            START: begin
                if (wrap_s && sampled_bit) se_d = 1'b1;
                else                       se_d = 1'b0;
            end
            STOP: begin
                if (wrap_s) begin
                    if (!sampled_bit)    sp_d = 1'b1;
                    else if (par_flag_s) pe_d = 1'b1;
                    else                 dv_d = 1'b1;
                end else begin
                    dv_d = 1'b0;
                end
            end
            default: begin
                dv_d = 1'b0;
                se_d = 1'b0;
            end
        endcase
    end

    // Pulse registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            dv_q <= 1'b0;
            se_q <= 1'b0;
            pe_q <= 1'b0;
            sp_q <= 1'b0;
        end else begin
            dv_q <= dv_d;
            se_q <= se_d;
            pe_q <= pe_d;
            sp_q <= sp_d;
        end
    end

    assign data_valid = dv_q;
    assign strt_err   = se_q;
    assign par_err    = pe_q;
    assign stp_err    = sp_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frame drivers push expected shift strobes
// and verdict pulses; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       sampled_bit;
`ifdef UART_RX_PARITY_EN
    logic       PAR_EN;
    logic       PAR_TYP;
`endif
    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic       deser_New_bit, deser_en, data_valid, strt_err, par_err, stp_err;

    typedef struct { int cyc; logic [3:0] kind; } ev_t;
    typedef struct { int cyc; logic b; } bit_t;

    ev_t  evq[$];
    bit_t bq[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   presc   = 8;
    logic [63:0] hist = '1;

    uart_rx_ctrl dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_IN         (RX_IN),
        .Prescale      (Prescale),
        .sampled_bit   (sampled_bit),
`ifdef UART_RX_PARITY_EN
        .PAR_EN        (PAR_EN),
        .PAR_TYP       (PAR_TYP),
`endif
        .dat_samp_en   (dat_samp_en),
        .edge_cnt      (edge_cnt),
        .deser_New_bit (deser_New_bit),
        .deser_en      (deser_en),
        .data_valid    (data_valid),
        .strt_err      (strt_err),
        .par_err       (par_err),
        .stp_err       (stp_err)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // One clock of line stimulus. sampled_bit mimics a mid-bit sampler by
    // replaying the line delayed by Prescale/2 cycles.
    task automatic tick(input logic line);
        @(posedge CLK);
        #1;
        hist        = {hist[62:0], RX_IN};
        RX_IN       = line;
        Prescale    = presc[5:0];
        sampled_bit = hist[presc/2-1];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1);
    endtask

    // Drive one frame; off is the cycle lag from line start to the DUT's first
    // START cycle (1 from idle, 2 when the frame follows a stop bit directly).
    task automatic frame(input logic [7:0] d, input int off, input logic par_on,
                         input logic par_typ, input logic par_flip, input logic stop_b,
                         input int nexp, input logic exp_end);
        logic [10:0] bits;
        int   nb;
        int   l;
        ev_t  e;
        bit_t b;
        nb        = par_on ? 11 : 10;
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
        if (par_on) begin
            bits[9]  = (^d) ^ par_typ ^ par_flip;
            bits[10] = stop_b;
        end else begin
            bits[9] = stop_b;
        end
`ifdef UART_RX_PARITY_EN
        PAR_EN  = par_on;
        PAR_TYP = par_typ;
`endif
        tick(bits[0]);
        l = cyc;
        for (int j = 0; j < nexp; j++) begin
            b.cyc = l + off + (j + 2) * presc - 1;
            b.b   = d[j];
            bq.push_back(b);
        end
        if (exp_end) begin
            e.cyc = l + off + nb * presc;
            if (!stop_b)                 e.kind = 4'b0001;
            else if (par_on && par_flip) e.kind = 4'b0010;
            else                         e.kind = 4'b1000;
            evq.push_back(e);
        end
        for (int k = 0; k < nb; k++)
            for (int c = 0; c < presc; c++)
                if (!(k == 0 && c == 0)) tick(bits[k]);
    endtask

    // Monitor: kind bits are {data_valid, strt_err, par_err, stp_err}
    initial begin
        forever begin
            bit_t eb;
            ev_t  ee;
            @(negedge CLK);
            if (deser_New_bit) begin
                if (bq.size() == 0) begin
                    chk("unexpected_new_bit", {cyc, 1'b1}, 64'd0);
                end else begin
                    eb = bq.pop_front();
                    chk("new_bit", {cyc, sampled_bit, deser_en}, {eb.cyc, eb.b, 1'b1});
                end
            end
            if ({data_valid, strt_err, par_err, stp_err} != 4'd0) begin
                if (evq.size() == 0) begin
                    chk("unexpected_pulse", {cyc, data_valid, strt_err, par_err, stp_err}, 64'd0);
                end else begin
                    ee = evq.pop_front();
                    chk("frame_pulse", {cyc, data_valid, strt_err, par_err, stp_err}, {ee.cyc, ee.kind});
                end
            end
        end
    end

    initial begin
        int  l;
        int  w;
        ev_t e;
        RST         = 1'b0;
        RX_IN       = 1'b1;
        sampled_bit = 1'b1;
        Prescale    = 6'd8;
`ifdef UART_RX_PARITY_EN
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
`endif
        idle(3);
        chk("rst_dat_samp_en", dat_samp_en, 64'd0);
        chk("rst_edge_cnt", edge_cnt, 64'd0);
        chk("rst_deser_en", deser_en, 64'd0);
        chk("rst_pulses", {deser_New_bit, data_valid, strt_err, par_err, stp_err}, 64'd0);
        RST = 1'b1;
        idle(4);

        // 0xA5 at Prescale 8: data_valid 80 cycles after START entry
        presc = 8;
        idle(2);
        frame(8'hA5, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b1);
        idle(6);

`ifdef UART_RX_PARITY_EN
        presc = 16;
        idle(2);
        frame(8'h3C, 1, 1'b1, 1'b0, 1'b0, 1'b1, 8, 1'b1);
        idle(6);
        frame(8'h3C, 1, 1'b1, 1'b0, 1'b1, 1'b1, 8, 1'b1);
        idle(6);
`endif

        // Start glitch: two low cycles, the start bit samples high
        presc = 8;
        idle(2);
        tick(1'b0);
        l      = cyc;
        e.cyc  = l + 1 + presc;
        e.kind = 4'b0100;
        evq.push_back(e);
        tick(1'b0);
        idle(presc + 6);

        // Broken stop bit at Prescale 32
        presc = 32;
        idle(2);
        frame(8'h55, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b1);
        idle(6);
`ifdef UART_RX_PARITY_EN
        frame(8'h55, 1, 1'b1, 1'b0, 1'b1, 1'b0, 8, 1'b1);
        idle(6);
`endif

        // Back-to-back: the second frame's start bit follows the stop bit
        // directly, and the DUT spends one IDLE cycle detecting it
        presc = 8;
        idle(2);
        frame(8'h01, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b1);
        frame(8'hFE, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b1);
        idle(6);

        // Reset in the middle of data bit 4, then a clean 0x81
        fork
            frame(8'hA5, 1, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0);
            begin
                repeat (5 * presc + 4) @(posedge CLK);
                #2;
                chk("pre_rst_edge_cnt", edge_cnt, 64'd2);
                chk("pre_rst_enables", {dat_samp_en, deser_en}, 64'd3);
                RST = 1'b0;
                #1;
                chk("mid_rst_edge_cnt", edge_cnt, 64'd0);
                chk("mid_rst_enables", {dat_samp_en, deser_en}, 64'd0);
                chk("mid_rst_pulses", {deser_New_bit, data_valid, strt_err, par_err, stp_err}, 64'd0);
            end
        join
        idle(3);
        RST = 1'b1;
        idle(4);
        frame(8'h81, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8, 1'b1);
        idle(6);

        w = 0;
        while ((evq.size() != 0 || bq.size() != 0) && w < 500) begin
            tick(1'b1);
            w++;
        end
        chk("events_drained", evq.size(), 64'd0);
        chk("bits_drained", bq.size(), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
